timer_irq_ctrl: RTL and testbench
=================================

// Module: timer_irq_ctrl
// PURPOSE
//  Interrupt/run controller sitting directly downstream of base_timer.
//  - Consumes base_timer o_trig; drives base_timer i_en via o_timer_en.
//  - Converts trigger pulses into a pending/acknowledge interrupt for the MIPS core.
//  - Supports periodic and one-shot modes; counts triggers lost while an IRQ is pending.
// PARAMETERS
//  MISS_W  8  width of missed-trigger counter (saturating)
// PORTS
//  i_clk       in   1       system clock, all logic on rising edge
//  i_srst      in   1       synchronous reset, active-high
//  i_trig      in   1       1-cycle overflow pulse from base_timer o_trig
//  i_cfg_we    in   1       config write strobe
//  i_cfg_data  in   3       {oneshot, irq_en, run}, bits [2:0]
//  i_ack       in   1       interrupt acknowledge, 1-cycle pulse from CPU
//  o_timer_en  out  1       count enable to base_timer i_en
//  o_pend      out  1       event pending (registered)
//  o_irq       out  1       interrupt request to core
//  o_state     out  2       FSM state for status readback
//  o_miss_cnt  out  MISS_W  triggers seen while pending
// BEHAVIOUR
//  - Reset (i_srst=1 at an edge): cfg=0, state=IDLE, o_pend=0, o_irq=0,
//    o_timer_en=0, o_miss_cnt=0. Reset overrides every other input.
//  - States: IDLE=0, ARMED=1, PENDING=2, DONE=3.
//  - o_timer_en = (state==ARMED) | (state==PENDING & ~oneshot); registered state
//    only, no combinational path from inputs.
//  - o_pend = (state==PENDING); o_irq = o_pend & cfg.irq_en.
//  - Priority per cycle: i_srst > i_cfg_we > i_trig/i_ack.
//  - Config write (any state): load cfg; clear o_miss_cnt;
//    next state = ARMED if run=1, else IDLE; pending event discarded.
//  - IDLE: hold; i_trig and i_ack ignored.
//  - ARMED: i_trig -> PENDING (o_pend/o_irq high the cycle after the pulse).
//    i_ack ignored.
//  - PENDING, periodic:
//    - i_trig & ~i_ack: stay; o_miss_cnt += 1, saturates at 2^MISS_W-1.
//    - i_ack & ~i_trig: -> ARMED.
//    - i_ack & i_trig: stay PENDING (new event replaces acked one); no miss increment.
//  - PENDING, one-shot: timer stopped; i_trig ignored (no miss increment);
//    i_ack -> DONE.
//  - DONE: o_timer_en=0; i_trig/i_ack ignored; left only by config write or reset.
//  - Latency: i_trig at edge N -> o_irq high after edge N; i_ack at edge M ->
//    o_irq low after edge M (unless simultaneous re-trigger).
//  - irq_en=0: FSM and o_pend behave identically; only o_irq is masked.
// CONFIGURATION
//  TIMER_IRQ_MISS_EN
//   - defined: missed-trigger counter implemented as above.
//   - undefined: no counter flops; o_miss_cnt tied to 0; FSM unchanged.
// TESTING
//  1. Reset with all inputs high -> all outputs 0, o_state=0.
//  2. cfg=3'b011, one i_trig -> o_pend=1, o_irq=1 next cycle, o_timer_en=1;
//     i_ack -> o_state=1, o_irq=0.
//  3. Periodic: while pending, 3 i_trig pulses -> o_miss_cnt=3;
//     i_ack with i_trig in the same cycle -> stays PENDING, o_miss_cnt=3.
//  4. One-shot cfg=3'b111: i_trig -> PENDING, o_timer_en=0;
//     further i_trig -> no miss; i_ack -> DONE (3), o_timer_en=0.
//  5. MISS_W=2: 5 missed triggers -> o_miss_cnt=3 (saturated);
//     cfg write -> o_miss_cnt=0.
//  6. cfg=3'b001 (irq_en=0): i_trig -> o_pend=1, o_irq=0;
//     cfg write run=0 in the same cycle as i_trig -> IDLE, o_pend=0.
//     Build without TIMER_IRQ_MISS_EN -> o_miss_cnt is always 0.

Source files
------------

// File: rtl/timer_irq_ctrl_if.sv
// Interface between timer_irq_ctrl and its neighbours: base_timer trigger/enable
// plus the CPU-side config, acknowledge and status signals.
interface timer_irq_ctrl_if #(
  parameter int unsigned MISS_W = 8
);
  logic              i_trig;
  logic              i_cfg_we;
  logic [2:0]        i_cfg_data;
  logic              i_ack;
  logic              o_timer_en;
  logic              o_pend;
  logic              o_irq;
  logic [1:0]        o_state;
  logic [MISS_W-1:0] o_miss_cnt;

  modport slave (
    input  i_trig, i_cfg_we, i_cfg_data, i_ack,
    output o_timer_en, o_pend, o_irq, o_state, o_miss_cnt
  );

  modport master (
    output i_trig, i_cfg_we, i_cfg_data, i_ack,
    input  o_timer_en, o_pend, o_irq, o_state, o_miss_cnt
  );
endinterface

// File: rtl/timer_irq_ctrl.sv
// Turns base_timer trigger pulses into a pending/ack interrupt, with periodic and one-shot modes.
// Optional TIMER_IRQ_MISS_EN adds a saturating counter of triggers lost while pending.
module timer_irq_ctrl #(
  parameter int unsigned MISS_W = 8
) (
  input  logic            i_clk,
  input  logic            i_srst,
  timer_irq_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    PENDING = 2'd2,
    DONE    = 2'd3
  } state_t;

  typedef struct packed {
    logic oneshot;
    logic irq_en;
    logic run;
  } cfg_t;

  state_t state_q, state_d;
  logic   oneshot_q, oneshot_d;
  logic   irq_en_q, irq_en_d;
  logic   timer_en_q, pend_q, irq_q;
  logic   timer_en_d, pend_d, irq_d;
  cfg_t   cfg_wr;

  assign cfg_wr = cfg_t'(bus.i_cfg_data);

  // Next state: a config write wins over trigger/ack and discards any pending event.
  always_comb begin
    state_d   = state_q;
    oneshot_d = oneshot_q;
    irq_en_d  = irq_en_q;
    if (bus.i_cfg_we) begin
      oneshot_d = cfg_wr.oneshot;
      irq_en_d  = cfg_wr.irq_en;
      state_d   = cfg_wr.run ? ARMED : IDLE;
    end else begin
      unique case (state_q)
        ARMED: begin
          if (bus.i_trig) state_d = PENDING;
        end
        PENDING: begin
          if (oneshot_q) begin
            if (bus.i_ack) state_d = DONE;
          end else if (bus.i_ack && !bus.i_trig) begin
            state_d = ARMED;
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs are computed from next state so the flops present them in step with state_q.
  always_comb begin
    timer_en_d = (state_d == ARMED) || ((state_d == PENDING) && !oneshot_d);
    pend_d     = (state_d == PENDING);
    irq_d      = pend_d && irq_en_d;
  end

  always_ff @(posedge i_clk) begin
    if (i_srst) begin
      state_q    <= IDLE;
      oneshot_q  <= 1'b0;
      irq_en_q   <= 1'b0;
      timer_en_q <= 1'b0;
      pend_q     <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      oneshot_q  <= oneshot_d;
      irq_en_q   <= irq_en_d;
      timer_en_q <= timer_en_d;
      pend_q     <= pend_d;
      irq_q      <= irq_d;
    end
  end

  assign bus.o_timer_en = timer_en_q;
  assign bus.o_pend     = pend_q;
  assign bus.o_irq      = irq_q;
  assign bus.o_state    = state_q;

`ifdef TIMER_IRQ_MISS_EN
  localparam logic [MISS_W-1:0] MISS_MAX = '1;

  logic [MISS_W-1:0] miss_q;
  logic              miss_hit;

  // A trigger counts as missed only in periodic PENDING when it is not paired with an ack.
  assign miss_hit = !bus.i_cfg_we && (state_q == PENDING) && !oneshot_q &&
                    bus.i_trig && !bus.i_ack;

  always_ff @(posedge i_clk) begin
    if (i_srst || bus.i_cfg_we) begin
      miss_q <= '0;
    end else if (miss_hit && (miss_q != MISS_MAX)) begin
      miss_q <= miss_q + MISS_W'(1);
    end
  end

  assign bus.o_miss_cnt = miss_q;
`else
  assign bus.o_miss_cnt = MISS_W'(0);
`endif

endmodule

// File: tb/tb_timer_irq_ctrl.sv
// Bench for timer_irq_ctrl: directed vector table, a saturation sequence and a random run
// against an event-level reference model; two instances (MISS_W=8 and MISS_W=2) share stimulus.
module tb_timer_irq_ctrl;

  logic       clk = 1'b0;
  logic       srst = 1'b1;
  logic       cfg_we = 1'b0;
  logic [2:0] cfg_data = 3'd0;
  logic       trig = 1'b0;
  logic       ack = 1'b0;

  always #5 clk = ~clk;

  timer_irq_ctrl_if #(.MISS_W(8)) bus8 ();
  timer_irq_ctrl_if #(.MISS_W(2)) bus2 ();

  assign bus8.i_trig     = trig;
  assign bus8.i_cfg_we   = cfg_we;
  assign bus8.i_cfg_data = cfg_data;
  assign bus8.i_ack      = ack;
  assign bus2.i_trig     = trig;
  assign bus2.i_cfg_we   = cfg_we;
  assign bus2.i_cfg_data = cfg_data;
  assign bus2.i_ack      = ack;

  timer_irq_ctrl #(.MISS_W(8)) u_dut8 (.i_clk(clk), .i_srst(srst), .bus(bus8.slave));
  timer_irq_ctrl #(.MISS_W(2)) u_dut2 (.i_clk(clk), .i_srst(srst), .bus(bus2.slave));

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: state number, config bits {oneshot, irq_en, run}, unbounded miss tally.
  int       m_state = 0;
  bit [2:0] m_cfg   = 3'd0;
  int       m_miss  = 0;

  typedef struct {
    bit       srst;
    bit       we;
    bit [2:0] d;
    bit       trig;
    bit       ack;
    int       st;
    bit       pend;
    bit       irq;
    bit       ten;
    int       miss;
  } vec_t;

  vec_t vt[$];

  function automatic int exp_miss(input int n, input int w);
`ifdef TIMER_IRQ_MISS_EN
    int mx;
    mx = (1 << w) - 1;
    return (n > mx) ? mx : n;
`else
    return (n > w) ? 0 : 0;
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic check_dut(input string tag, input int st, input bit p, input bit i,
                           input bit e, input int n);
    check({tag, ".state8"}, 32'(bus8.o_state), 32'(st));
    check({tag, ".pend8"},  32'(bus8.o_pend), 32'(p));
    check({tag, ".irq8"},   32'(bus8.o_irq), 32'(i));
    check({tag, ".ten8"},   32'(bus8.o_timer_en), 32'(e));
    check({tag, ".miss8"},  32'(bus8.o_miss_cnt), 32'(exp_miss(n, 8)));
    check({tag, ".state2"}, 32'(bus2.o_state), 32'(st));
    check({tag, ".irq2"},   32'(bus2.o_irq), 32'(i));
    check({tag, ".ten2"},   32'(bus2.o_timer_en), 32'(e));
    check({tag, ".miss2"},  32'(bus2.o_miss_cnt), 32'(exp_miss(n, 2)));
  endtask

  // Event-level rules: reset, then config write, then trigger/ack handling per state.
  task automatic model_step(input bit s, input bit w, input bit [2:0] d, input bit t, input bit a);
    if (s) begin
      m_state = 0; m_cfg = 3'd0; m_miss = 0;
    end else if (w) begin
      m_cfg = d; m_miss = 0; m_state = d[0] ? 1 : 0;
    end else if (m_state == 1) begin
      if (t) m_state = 2;
    end else if (m_state == 2) begin
      if (m_cfg[2]) begin
        if (a) m_state = 3;
      end else if (a && !t) begin
        m_state = 1;
      end else if (t && !a) begin
        m_miss = m_miss + 1;
      end
    end
  endtask

  task automatic check_model(input string tag);
    bit p;
    p = (m_state == 2);
    check_dut(tag, m_state, p, p && m_cfg[1],
              (m_state == 1) || (p && !m_cfg[2]), m_miss);
  endtask

  task automatic cycle(input bit s, input bit w, input bit [2:0] d, input bit t, input bit a);
    @(negedge clk);
    srst = s; cfg_we = w; cfg_data = d; trig = t; ack = a;
    @(posedge clk);
    model_step(s, w, d, t, a);
    #1;
  endtask

  task automatic add(input bit s, input bit w, input bit [2:0] d, input bit t, input bit a,
                     input int st, input bit p, input bit i, input bit e, input int m);
    vec_t v;
    v.srst = s; v.we = w; v.d = d; v.trig = t; v.ack = a;
    v.st = st; v.pend = p; v.irq = i; v.ten = e; v.miss = m;
    vt.push_back(v);
  endtask

  initial begin
    //   srst we d     trig ack | st pend irq ten miss
    add(1, 1, 3'd7, 1, 1,   0, 0, 0, 0, 0);  // reset with all inputs high
    add(0, 1, 3'd3, 0, 0,   1, 0, 0, 1, 0);  // periodic, irq enabled
    add(0, 0, 3'd0, 1, 0,   2, 1, 1, 1, 0);
    add(0, 0, 3'd0, 0, 1,   1, 0, 0, 1, 0);
    add(0, 0, 3'd0, 1, 0,   2, 1, 1, 1, 0);
    add(0, 0, 3'd0, 1, 0,   2, 1, 1, 1, 1);
    add(0, 0, 3'd0, 1, 0,   2, 1, 1, 1, 2);
    add(0, 0, 3'd0, 1, 0,   2, 1, 1, 1, 3);
    add(0, 0, 3'd0, 1, 1,   2, 1, 1, 1, 3);  // ack + re-trigger: stays, no miss
    add(0, 0, 3'd0, 0, 1,   1, 0, 0, 1, 3);
    add(0, 0, 3'd0, 1, 0,   2, 1, 1, 1, 3);
    add(0, 0, 3'd0, 1, 0,   2, 1, 1, 1, 4);
    add(0, 0, 3'd0, 1, 0,   2, 1, 1, 1, 5);  // MISS_W=2 instance saturated at 3
    add(0, 1, 3'd7, 0, 0,   1, 0, 0, 1, 0);  // one-shot
    add(0, 0, 3'd0, 1, 0,   2, 1, 1, 0, 0);
    add(0, 0, 3'd0, 1, 0,   2, 1, 1, 0, 0);
    add(0, 0, 3'd0, 0, 1,   3, 0, 0, 0, 0);
    add(0, 0, 3'd0, 1, 1,   3, 0, 0, 0, 0);
    add(0, 1, 3'd1, 0, 0,   1, 0, 0, 1, 0);  // irq masked
    add(0, 0, 3'd0, 1, 0,   2, 1, 0, 1, 0);
    add(0, 1, 3'd0, 1, 0,   0, 0, 0, 0, 0);  // cfg write beats trigger
    add(0, 0, 3'd0, 1, 1,   0, 0, 0, 0, 0);
    add(0, 1, 3'd3, 0, 0,   1, 0, 0, 1, 0);
    add(0, 0, 3'd0, 0, 1,   1, 0, 0, 1, 0);
    add(0, 0, 3'd0, 1, 0,   2, 1, 1, 1, 0);
    add(0, 0, 3'd0, 1, 0,   2, 1, 1, 1, 1);
    add(0, 1, 3'd3, 1, 1,   1, 0, 0, 1, 0);  // pending event discarded by cfg write
    add(0, 0, 3'd0, 1, 0,   2, 1, 1, 1, 0);
    add(1, 1, 3'd3, 1, 0,   0, 0, 0, 0, 0);  // reset beats cfg write
    add(0, 0, 3'd0, 1, 0,   0, 0, 0, 0, 0);

    foreach (vt[i]) begin
      cycle(vt[i].srst, vt[i].we, vt[i].d, vt[i].trig, vt[i].ack);
      check_dut($sformatf("vec%0d", i), vt[i].st, vt[i].pend, vt[i].irq, vt[i].ten, vt[i].miss);
    end

    // Full-width saturation of the 8-bit counter, then clear on config write.
    cycle(0, 1, 3'd3, 0, 0);
    cycle(0, 0, 3'd0, 1, 0);
    repeat (256) cycle(0, 0, 3'd0, 1, 0);
    check("sat8", 32'(bus8.o_miss_cnt), 32'(exp_miss(256, 8)));
    check_model("sat");
    cycle(0, 1, 3'd3, 0, 0);
    check("clr8", 32'(bus8.o_miss_cnt), 32'd0);
    check("clr2", 32'(bus2.o_miss_cnt), 32'd0);

    for (int k = 0; k < 3000; k++) begin
      bit       s, w, t, a;
      bit [2:0] d;
      s = ($urandom_range(0, 99) == 0);
      w = ($urandom_range(0, 19) == 0);
      d = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) != 0) d[0] = 1'b1;
      t = ($urandom_range(0, 2) == 0);
      a = ($urandom_range(0, 3) == 0);
      cycle(s, w, d, t, a);
      check_model($sformatf("rnd%0d", k));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
